clic_irq_sender: RTL and testbench
==================================

Name: clic_irq_sender

Overview:
- Interrupt-controller-side transmitter for the core's CLIC interrupt interface. The core is the receiver, consuming valid/id/level/priv/shv and returning ready, kill_ack.
- Selects the highest-level pending, enabled source above a threshold, presents it to the core, and handles acceptance or kill/retraction.
- Issues a one-cycle claim to the source logic so edge-triggered pending bits can be cleared.
- Sits between the CLIC source/register file and the CVA6 core.

Parameters:
NumSrc, 256, number of interrupt sources (>=2)
IdWidth, $clog2(NumSrc), source id width
LevelWidth, 8, interrupt level width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
intr_pending_i  in  NumSrc  per-source pending
intr_enable_i  in  NumSrc  per-source enable
intr_level_i  in  NumSrc*LevelWidth  per-source level, source i at [i*LevelWidth +: LevelWidth]
intr_priv_i  in  NumSrc*2  per-source privilege mode
intr_shv_i  in  NumSrc  per-source selective hardware vectoring
mintthresh_i  in  LevelWidth  minimum level threshold
clic_irq_valid_o  out  1  interrupt offered to core
clic_irq_ready_i  in  1  core accepts offered interrupt
clic_irq_id_o  out  IdWidth  offered id
clic_irq_level_o  out  LevelWidth  offered level
clic_irq_priv_o  out  2  offered privilege
clic_irq_shv_o  out  1  offered shv
clic_kill_req_o  out  1  request retraction of offer
clic_kill_ack_i  in  1  core acknowledges retraction
claim_valid_o  out  1  one-cycle pulse: offer accepted
claim_id_o  out  IdWidth  id accepted

Behaviour:
- Reset: all outputs 0; FSM in IDLE; candidate register invalid.
- Arbitration stage:
  - eligible(i) = pending & enable & (level > mintthresh_i).
  - Pick the maximum level; ties go to the lowest id.
  - Result (valid, id, level, priv, shv) is registered every cycle, giving 1 cycle of latency.
- FSM states IDLE, REQ, KILL.
- IDLE:
  - If the candidate register is valid, load it into the output registers and go to REQ.
  - Latency: source eligible in cycle N → clic_irq_valid_o high in cycle N+2.
- REQ:
  - clic_irq_valid_o=1; id/level/priv/shv held stable.
  - clic_irq_ready_i=1: claim_valid_o=1 next cycle with claim_id_o=id; valid drops next cycle; go to IDLE.
  - Else, if the offered source is no longer eligible (pending/enable dropped, or level <= mintthresh_i), or the candidate level is strictly greater than the offered level: assert clic_kill_req_o next cycle and go to KILL.
  - Ready takes priority over any kill condition in the same cycle.
- KILL:
  - clic_kill_req_o=1 and clic_irq_valid_o=1 until resolved.
  - clic_kill_ack_i=1: drop valid and kill_req next cycle, no claim, go to IDLE.
  - clic_irq_ready_i=1 (core took it before the kill): treat as accept, issue claim, go to IDLE.
  - Ready and kill_ack in the same cycle: ready wins, claim issued.
- After IDLE is re-entered, at least 1 cycle passes before the next offer, so valid deasserts for at least one cycle between offers.
- Equal-level newcomers never preempt.
- Outputs are registered; no combinational path from inputs to outputs.
- mintthresh_i changes are sampled through the eligibility logic only; an in-flight offer is killed via the eligibility check.
- Reset asserted mid-operation returns to IDLE with all outputs 0 immediately (asynchronous); no claim is issued.

Optional Feature:
CLIC_SENDER_SHV_EN
- Defined: clic_irq_shv_o carries the selected source's intr_shv_i bit.
- Undefined: clic_irq_shv_o is tied to 0 and intr_shv_i is ignored; all interrupts are non-vectored.

Test Plan:
- Single source: id 5, level 0x40, mintthresh 0x10, pending at cycle N → valid at N+2 with id 5, level 0x40; ready at N+3 → claim_valid_o=1, claim_id_o=5 at N+4; valid=0 at N+4.
- Tie and priority: ids 3 and 7 at level 0x80, id 9 at 0x7F → offer id 3; after claim with id 3 cleared, next offer id 7.
- Preemption: offering id 2 at level 0x20, id 10 rises at 0x90 → kill_req_o=1; kill_ack_i → valid drops, no claim; next offer id 10, level 0x90.
- Ready wins over kill: offering id 4 while kill_req_o=1; ready and kill_ack in the same cycle → claim id 4, no re-offer of id 4 if its pending is cleared.
- Threshold: level 0x10 with mintthresh 0x10 → never offered; mintthresh raised to 0x50 while offering level 0x40 → kill issued.
- Reset mid-REQ: rst_ni low while valid=1 → all outputs 0 immediately; after release with the source still pending → re-offered after 2 cycles.

Source files
------------

// File: rtl/clic_irq_sender.sv
// -----------------------------------------------------------------------------
// clic_irq_sender
//
// Interrupt-controller-side transmitter for the core's CLIC interrupt port.
// Picks the highest-level pending, enabled source whose level is above
// mintthresh_i and offers it to the core. The offer ends in one of two ways.
// If the core accepts it, a one-cycle claim pulse goes back to the source logic
// so that edge-triggered pending bits can be cleared. If it goes stale, the
// offer is retracted with a kill request.
//
// Optional feature macro: CLIC_SENDER_SHV_EN
//   defined   : clic_irq_shv_o carries the selected source's intr_shv_i bit
//   undefined : clic_irq_shv_o is always 0 and intr_shv_i is ignored
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   intr_pending_i       per-source pending
//   intr_enable_i        per-source enable
//   intr_level_i         per-source level, source i at [i*LevelWidth +: LevelWidth]
//   intr_priv_i          per-source privilege, source i at [i*2 +: 2]
//   intr_shv_i           per-source selective hardware vectoring
//   mintthresh_i         a source is eligible only if its level is strictly above this
//   clic_irq_valid_o     interrupt offered to the core
//   clic_irq_ready_i     core accepts the offer
//   clic_irq_id_o/level_o/priv_o/shv_o   offered interrupt, stable while offered
//   clic_kill_req_o      retraction request for the current offer
//   clic_kill_ack_i      core acknowledges the retraction
//   claim_valid_o        one-cycle pulse when an offer is accepted
//   claim_id_o           id of the most recently accepted offer
//
// States:
//   state | meaning
//   IDLE  | nothing offered; load the candidate register when it is valid
//   REQ   | offer presented; wait for ready or detect a stale offer
//   KILL  | offer presented with kill_req; wait for ready or kill_ack
// -----------------------------------------------------------------------------
module clic_irq_sender #(
    parameter int unsigned NumSrc     = 256,
    parameter int unsigned IdWidth    = $clog2(NumSrc),
    parameter int unsigned LevelWidth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumSrc-1:0]            intr_pending_i,
    input  logic [NumSrc-1:0]            intr_enable_i,
    input  logic [NumSrc*LevelWidth-1:0] intr_level_i,
    input  logic [NumSrc*2-1:0]          intr_priv_i,
    input  logic [NumSrc-1:0]            intr_shv_i,
    input  logic [LevelWidth-1:0]        mintthresh_i,
    output logic                         clic_irq_valid_o,
    input  logic                         clic_irq_ready_i,
    output logic [IdWidth-1:0]           clic_irq_id_o,
    output logic [LevelWidth-1:0]        clic_irq_level_o,
    output logic [1:0]                   clic_irq_priv_o,
    output logic                         clic_irq_shv_o,
    output logic                         clic_kill_req_o,
    input  logic                         clic_kill_ack_i,
    output logic                         claim_valid_o,
    output logic [IdWidth-1:0]           claim_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_KILL = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Arbitration result, registered as the candidate.
    logic [NumSrc-1:0]     elig;
    logic                  cand_valid_d, cand_valid_q;
    logic [IdWidth-1:0]    cand_id_d, cand_id_q;
    logic [LevelWidth-1:0] cand_level_d, cand_level_q;
    logic [1:0]            cand_priv_d, cand_priv_q;
    logic                  cand_shv_d, cand_shv_q;

    // Offer and claim registers drive the outputs directly.
    logic                  valid_d, valid_q;
    logic [IdWidth-1:0]    id_d, id_q;
    logic [LevelWidth-1:0] level_d, level_q;
    logic [1:0]            priv_d, priv_q;
    logic                  shv_d, shv_q;
    logic                  kill_d, kill_q;
    logic                  claim_valid_d, claim_valid_q;
    logic [IdWidth-1:0]    claim_id_d, claim_id_q;

    logic offer_elig;
    logic kill_cond;
    logic accept;
    logic retire;

`ifndef CLIC_SENDER_SHV_EN
    // Vectoring is disabled, so the per-source shv bits go nowhere.
    logic unused_shv;
    assign unused_shv = ^intr_shv_i;
`endif

    // A later source replaces the current best only when its level is strictly
    // higher, so on a tie the lowest id wins.
    always_comb begin
        elig         = '0;
        cand_valid_d = 1'b0;
        cand_id_d    = '0;
        cand_level_d = '0;
        cand_priv_d  = '0;
        cand_shv_d   = 1'b0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            elig[i] = intr_pending_i[i] & intr_enable_i[i] &
                      (intr_level_i[i*LevelWidth +: LevelWidth] > mintthresh_i);
            if (elig[i] && (!cand_valid_d ||
                            (intr_level_i[i*LevelWidth +: LevelWidth] > cand_level_d))) begin
                cand_valid_d = 1'b1;
                cand_id_d    = IdWidth'(i);
                cand_level_d = intr_level_i[i*LevelWidth +: LevelWidth];
                cand_priv_d  = intr_priv_i[i*2 +: 2];
`ifdef CLIC_SENDER_SHV_EN
                cand_shv_d   = intr_shv_i[i];
`endif
            end
        end
    end

    // The offered source is re-checked against the live inputs, so threshold
    // or enable changes retract an in-flight offer. Only a strictly higher
    // candidate level counts as preemption.
    assign offer_elig = elig[id_q];
    assign kill_cond  = !offer_elig || (cand_valid_q && (cand_level_q > level_q));

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        id_d          = id_q;
        level_d       = level_q;
        priv_d        = priv_q;
        shv_d         = shv_q;
        kill_d        = kill_q;
        claim_valid_d = 1'b0;
        claim_id_d    = claim_id_q;
        accept        = 1'b0;
        retire        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cand_valid_q) begin
                    state_d = ST_REQ;
                    valid_d = 1'b1;
                    id_d    = cand_id_q;
                    level_d = cand_level_q;
                    priv_d  = cand_priv_q;
                    shv_d   = cand_shv_q;
                end
            end
            ST_REQ: begin
                if (clic_irq_ready_i) begin
                    accept = 1'b1;
                end else if (kill_cond) begin
                    state_d = ST_KILL;
                    kill_d  = 1'b1;
                end
            end
            ST_KILL: begin
                // The core may have taken the interrupt before seeing the kill.
                if (clic_irq_ready_i) begin
                    accept = 1'b1;
                end else if (clic_kill_ack_i) begin
                    retire = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Going back to IDLE costs one cycle with valid low before the next
        // offer can be loaded.
        if (accept || retire) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            kill_d  = 1'b0;
            id_d    = '0;
            level_d = '0;
            priv_d  = '0;
            shv_d   = 1'b0;
        end
        if (accept) begin
            claim_valid_d = 1'b1;
            claim_id_d    = id_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cand_valid_q  <= 1'b0;
            cand_id_q     <= '0;
            cand_level_q  <= '0;
            cand_priv_q   <= '0;
            cand_shv_q    <= 1'b0;
            valid_q       <= 1'b0;
            id_q          <= '0;
            level_q       <= '0;
            priv_q        <= '0;
            shv_q         <= 1'b0;
            kill_q        <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            cand_valid_q  <= cand_valid_d;
            cand_id_q     <= cand_id_d;
            cand_level_q  <= cand_level_d;
            cand_priv_q   <= cand_priv_d;
            cand_shv_q    <= cand_shv_d;
            valid_q       <= valid_d;
            id_q          <= id_d;
            level_q       <= level_d;
            priv_q        <= priv_d;
            shv_q         <= shv_d;
            kill_q        <= kill_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
        end
    end

    assign clic_irq_valid_o = valid_q;
    assign clic_irq_id_o    = id_q;
    assign clic_irq_level_o = level_q;
    assign clic_irq_priv_o  = priv_q;
    assign clic_irq_shv_o   = shv_q;
    assign clic_kill_req_o  = kill_q;
    assign claim_valid_o    = claim_valid_q;
    assign claim_id_o       = claim_id_q;

endmodule

// File: tb/tb_clic_irq_sender.sv
// -----------------------------------------------------------------------------
// tb_clic_irq_sender
//
// Directed bench for clic_irq_sender with 16 sources. A behavioural model tracks
// the offer/kill/claim protocol at transaction level. A compare process checks
// every output against that model on each falling edge. Literal checks in the
// directed sequences pin latency and selection results.
// -----------------------------------------------------------------------------
module tb_clic_irq_sender;

    localparam int N  = 16;
    localparam int LW = 8;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]  pend = '0;
    logic [N-1:0]  en   = '0;
    logic [N-1:0]  shv  = '0;
    logic [LW-1:0] lvl [N];
    logic [1:0]    prv [N];
    logic [LW-1:0] thr   = '0;
    logic          ready = 1'b0;
    logic          kack  = 1'b0;

    logic [N*LW-1:0] level_bus;
    logic [2*N-1:0]  priv_bus;

    always_comb begin
        level_bus = '0;
        priv_bus  = '0;
        for (int i = 0; i < N; i++) begin
            level_bus[i*LW +: LW] = lvl[i];
            priv_bus[i*2 +: 2]    = prv[i];
        end
    end

    logic          valid;
    logic [IW-1:0] id;
    logic [LW-1:0] level;
    logic [1:0]    priv;
    logic          shv_o;
    logic          kill;
    logic          claim;
    logic [IW-1:0] claim_id;

    clic_irq_sender #(.NumSrc(N), .IdWidth(IW), .LevelWidth(LW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .intr_pending_i   (pend),
        .intr_enable_i    (en),
        .intr_level_i     (level_bus),
        .intr_priv_i      (priv_bus),
        .intr_shv_i       (shv),
        .mintthresh_i     (thr),
        .clic_irq_valid_o (valid),
        .clic_irq_ready_i (ready),
        .clic_irq_id_o    (id),
        .clic_irq_level_o (level),
        .clic_irq_priv_o  (priv),
        .clic_irq_shv_o   (shv_o),
        .clic_kill_req_o  (kill),
        .clic_kill_ack_i  (kack),
        .claim_valid_o    (claim),
        .claim_id_o       (claim_id)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_elig(input int i);
        return pend[i] && en[i] && (lvl[i] > thr);
    endfunction

    // Find the top level first, then the lowest id at that level.
    function automatic void pick(output bit v, output int sel);
        int mx;
        mx  = -1;
        v   = 1'b0;
        sel = 0;
        for (int i = 0; i < N; i++)
            if (is_elig(i) && int'(lvl[i]) > mx) mx = int'(lvl[i]);
        for (int i = 0; i < N; i++)
            if (!v && is_elig(i) && int'(lvl[i]) == mx) begin
                v   = 1'b1;
                sel = i;
            end
    endfunction

    bit            c_v;
    int            c_id;
    logic [LW-1:0] c_l;
    logic [1:0]    c_p;
    logic          c_s;
    bit            m_off, m_kill, m_claim;
    int            m_id, m_claim_id;
    logic [LW-1:0] m_l;
    logic [1:0]    m_p;
    logic          m_s;
    bit            n_v;
    int            n_id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_v = 0; c_id = 0; c_l = '0; c_p = '0; c_s = 1'b0;
            m_off = 0; m_kill = 0; m_claim = 0; m_id = 0; m_claim_id = 0;
            m_l = '0; m_p = '0; m_s = 1'b0;
        end else begin
            pick(n_v, n_id);
            m_claim = 0;
            if (!m_off) begin
                if (c_v) begin
                    m_off = 1; m_id = c_id; m_l = c_l; m_p = c_p; m_s = c_s;
                end
            end else if (ready) begin
                m_claim = 1; m_claim_id = m_id; m_off = 0; m_kill = 0;
            end else if (m_kill) begin
                if (kack) begin
                    m_off = 0; m_kill = 0;
                end
            end else if (!is_elig(m_id) || (c_v && c_l > m_l)) begin
                m_kill = 1;
            end
            c_v  = n_v;
            c_id = n_id;
            c_l  = lvl[n_id];
            c_p  = prv[n_id];
`ifdef CLIC_SENDER_SHV_EN
            c_s  = shv[n_id];
`else
            c_s  = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid",    valid,    m_off);
            check("m_kill",     kill,     m_kill);
            check("m_id",       id,       m_off ? m_id : 0);
            check("m_level",    level,    m_off ? m_l : '0);
            check("m_priv",     priv,     m_off ? m_p : '0);
            check("m_shv",      shv_o,    m_off ? m_s : 1'b0);
            check("m_claim",    claim,    m_claim);
            check("m_claim_id", claim_id, m_claim_id);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic p, input logic [LW-1:0] l);
        pend[i] = p;
        en[i]   = 1'b1;
        lvl[i]  = l;
    endtask

    task automatic wait_for(input int which, input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = (which == 0) ? valid : kill;
        end
        check({nm, "_timeout"}, ok, 1);
    endtask

    task automatic accept(input int i, input string nm);
        ready   = 1'b1;
        pend[i] = 1'b0;
        cyc(1);
        ready = 1'b0;
        check({nm, "_claim"},    claim,    1);
        check({nm, "_claim_id"}, claim_id, i);
        check({nm, "_drop"},     valid,    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            lvl[i] = '0;
            prv[i] = 2'(i);
        end
        shv = 16'hA5C3;
        #1;
        check("rst_valid", valid, 0);
        check("rst_kill",  kill,  0);
        check("rst_claim", claim, 0);
        check("rst_id",    id,    0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // single source: latency, payload, claim
        set_src(5, 1'b1, 8'h40);
        thr = 8'h10;
        cyc(1);
        check("t1_lat1", valid, 0);
        cyc(1);
        check("t1_lat2",  valid, 1);
        check("t1_id",    id,    5);
        check("t1_level", level, 8'h40);
        check("t1_priv",  priv,  1);
        cyc(1);
        check("t1_hold", valid, 1);
        accept(5, "t1");
        cyc(3);
        check("t1_no_reoffer", valid, 0);

        // tie goes to lowest id, then next in order
        set_src(3, 1'b1, 8'h80);
        set_src(7, 1'b1, 8'h80);
        set_src(9, 1'b1, 8'h7F);
        wait_for(0, "t2a");
        check("t2_first", id, 3);
        accept(3, "t2a");
        wait_for(0, "t2b");
        check("t2_second", id, 7);
        check("t2_second_lvl", level, 8'h80);
        accept(7, "t2b");
        wait_for(0, "t2c");
        check("t2_third", id, 9);
        accept(9, "t2c");
        cyc(2);

        // preemption by a strictly higher level
        set_src(2, 1'b1, 8'h20);
        wait_for(0, "t3a");
        check("t3_id2", id, 2);
        set_src(10, 1'b1, 8'h90);
        wait_for(1, "t3_kill");
        check("t3_kill_valid", valid, 1);
        kack = 1'b1;
        cyc(1);
        kack = 1'b0;
        check("t3_drop_valid", valid, 0);
        check("t3_drop_kill",  kill,  0);
        check("t3_no_claim",   claim, 0);
        wait_for(0, "t3b");
        check("t3_id10",  id,    10);
        check("t3_lvl90", level, 8'h90);
        accept(10, "t3b");
        wait_for(0, "t3c");
        check("t3_reoffer2", id, 2);
        accept(2, "t3c");
        cyc(2);

        // equal-level newcomer does not preempt
        set_src(12, 1'b1, 8'h33);
        wait_for(0, "t3d");
        set_src(1, 1'b1, 8'h33);
        cyc(3);
        check("t3_eq_no_kill", kill, 0);
        check("t3_eq_id", id, 12);
        accept(12, "t3d");
        wait_for(0, "t3e");
        check("t3_eq_next", id, 1);
        accept(1, "t3e");
        cyc(2);

        // ready and kill_ack together: ready wins
        set_src(4, 1'b1, 8'h30);
        wait_for(0, "t4a");
        check("t4_id4", id, 4);
        set_src(11, 1'b1, 8'h60);
        wait_for(1, "t4_kill");
        ready   = 1'b1;
        kack    = 1'b1;
        pend[4] = 1'b0;
        cyc(1);
        ready = 1'b0;
        kack  = 1'b0;
        check("t4_claim",    claim,    1);
        check("t4_claim_id", claim_id, 4);
        check("t4_drop",     valid,    0);
        wait_for(0, "t4b");
        check("t4_next11", id, 11);
        accept(11, "t4b");
        cyc(2);

        // threshold: equal is not eligible; raising it kills the offer
        set_src(6, 1'b1, 8'h10);
        cyc(5);
        check("t5_eq_thr", valid, 0);
        pend[6] = 1'b0;
        cyc(1);
        set_src(6, 1'b1, 8'h40);
        wait_for(0, "t5a");
        check("t5_id6", id, 6);
        thr = 8'h50;
        cyc(1);
        check("t5_kill", kill, 1);
        kack = 1'b1;
        cyc(1);
        kack = 1'b0;
        check("t5_drop", valid, 0);
        cyc(3);
        check("t5_below_thr", valid, 0);
        pend[6] = 1'b0;
        thr = 8'h10;
        cyc(2);

        // asynchronous reset while offering
        set_src(8, 1'b1, 8'h55);
        wait_for(0, "t6a");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", valid, 0);
        check("t6_rst_id",    id,    0);
        check("t6_rst_level", level, 0);
        check("t6_rst_kill",  kill,  0);
        check("t6_rst_claim", claim, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("t6_lat1", valid, 0);
        cyc(1);
        check("t6_lat2", valid, 1);
        check("t6_id8",  id,    8);
        accept(8, "t6");
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
